mem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: r0 (instruction fetch, read-only in practice) and r1 (load_store_queue `mem_*` interface).
- Grants one transaction at a time. Registers the granted request onto the memory port, holds it until `m_ack`, then returns a registered one-cycle ack and read data to the winner.
- A watchdog terminates hung transactions.

---
 rtl/mem_port_arbiter_if.sv | 20 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory-style request/response bus shared by requesters and the memory port.
// master drives req/we/addr/wdata; slave returns ack/rdata.
interface mem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the data-memory port, with a watchdog.
// Ports: clk, rst_n, r0/r1 (slave buses), m (master bus), grant_id, busy, timeout_err.
module mem_port_arbiter #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave  r0,
  mem_port_arbiter_if.slave  r1,
  mem_port_arbiter_if.master m,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic       FP       = (FIXED_PRIO != 0);
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        terr_q, terr_d;
  logic        both;
  logic        win;

  assign both = r0.req & r1.req;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (both & FP):        win = 1'b1;
      (both & ~FP):       win = ~last_q;
      (r1.req & ~r0.req): win = 1'b1;
      default:            win = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = 2'b00;
    rdata_d = '0;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (r0.req || r1.req) begin
          req_d   = 1'b1;
          we_d    = win ? r1.we    : r0.we;
          addr_d  = win ? r1.addr  : r0.addr;
          wdata_d = win ? r1.wdata : r0.wdata;
          grant_d = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        unique case (1'b1)
          m.ack: begin
            rdata_d = m.rdata;
            ack_d   = grant_q ? 2'b10 : 2'b01;
            req_d   = 1'b0;
            state_d = RESP;
          end
          (!m.ack && cnt_q >= LAST_CNT): begin
            rdata_d = ERR_DATA;
            ack_d   = grant_q ? 2'b10 : 2'b01;
            req_d   = 1'b0;
            terr_d  = 1'b1;
            state_d = RESP;
          end
          default: begin
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        endcase
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      ack_q   <= 2'b00;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  assign m.req       = req_q;
  assign m.we        = we_q;
  assign m.addr      = addr_q;
  assign m.wdata     = wdata_q;
  assign r0.ack      = ack_q[0];
  assign r1.ack      = ack_q[1];
  assign r0.rdata    = ack_q[0] ? rdata_q : '0;
  assign r1.rdata    = ack_q[1] ? rdata_q : '0;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: round-robin and fixed-priority instances.
// Directed stimulus; monitors check memory-side requests and requester acks.
module tb_mem_port_arbiter;

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dur;
  } mexp_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        terr;
  } rexp_t;

  logic clk;
  logic rst_n;
  logic fp_rst_n;
  logic grant_id, busy, timeout_err;
  logic fp_grant, fp_busy, fp_terr;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = -1;
  logic [31:0] mem_data = '0;
  logic stray = 1'b0;

  mexp_t exp_m[$];
  rexp_t exp_r[$];
  logic  exp_fp[$];

  mem_port_arbiter_if rr_r0();
  mem_port_arbiter_if rr_r1();
  mem_port_arbiter_if rr_m();
  mem_port_arbiter_if fp_r0();
  mem_port_arbiter_if fp_r1();
  mem_port_arbiter_if fp_m();

  mem_port_arbiter #(
    .FIXED_PRIO(0),
    .TIMEOUT_CYCLES(4)
  ) u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .r0(rr_r0),
    .r1(rr_r1),
    .m(rr_m),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  mem_port_arbiter #(
    .FIXED_PRIO(1),
    .TIMEOUT_CYCLES(4)
  ) u_fp (
    .clk(clk),
    .rst_n(fp_rst_n),
    .r0(fp_r0),
    .r1(fp_r1),
    .m(fp_m),
    .grant_id(fp_grant),
    .busy(fp_busy),
    .timeout_err(fp_terr)
  );

  assign fp_r0.req   = rr_r0.req;
  assign fp_r0.we    = rr_r0.we;
  assign fp_r0.addr  = rr_r0.addr;
  assign fp_r0.wdata = rr_r0.wdata;
  assign fp_r1.req   = rr_r1.req;
  assign fp_r1.we    = rr_r1.we;
  assign fp_r1.addr  = rr_r1.addr;
  assign fp_r1.wdata = rr_r1.wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model for the round-robin instance: ack after mem_lat cycles.
  initial begin
    int cyc;
    cyc = 0;
    rr_m.ack = 1'b0;
    rr_m.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      rr_m.ack = 1'b0;
      rr_m.rdata = '0;
      if (stray) begin
        rr_m.ack = 1'b1;
        rr_m.rdata = 32'h0BAD_0BAD;
        stray = 1'b0;
      end else if (!rr_m.req) begin
        cyc = 0;
      end else begin
        if (cyc == mem_lat) begin
          rr_m.ack = 1'b1;
          rr_m.rdata = mem_data;
        end
        cyc++;
      end
    end
  end

  // Memory model for the fixed-priority instance: ack in the first cycle.
  initial begin
    fp_m.ack = 1'b0;
    fp_m.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      fp_m.ack = fp_m.req;
    end
  end

  // Memory-side monitor: payload at grant, stability, request duration.
  initial begin
    mexp_t cur;
    int dur;
    logic prev;
    prev = 1'b0;
    dur = 0;
    cur = '{1'b0, 1'b0, 32'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (rr_m.req && !prev) begin
          if (exp_m.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL m_unexpected_req: got addr %h want no request",
                     rr_m.addr);
          end else begin
            cur = exp_m.pop_front();
            chk("m_grant", 32'(grant_id), 32'(cur.id));
            chk("m_we", 32'(rr_m.we), 32'(cur.we));
            chk("m_addr", rr_m.addr, cur.addr);
            chk("m_wdata", rr_m.wdata, cur.wdata);
            chk("m_busy", 32'(busy), 32'd1);
          end
          dur = 1;
        end else if (rr_m.req) begin
          dur++;
          chk("m_hold_we", 32'(rr_m.we), 32'(cur.we));
          chk("m_hold_addr", rr_m.addr, cur.addr);
          chk("m_hold_wdata", rr_m.wdata, cur.wdata);
        end else if (prev) begin
          chk("m_req_cycles", 32'(dur), 32'(cur.dur));
        end
        prev = rr_m.req;
      end
    end
  end

  // Requester-side monitor: every ack pulse must match the next expectation.
  initial begin
    rexp_t re;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rr_r0.ack || rr_r1.ack) begin
          if (exp_r.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL r_unexpected_ack: got r0_ack=%b r1_ack=%b want none",
                     rr_r0.ack, rr_r1.ack);
          end else begin
            re = exp_r.pop_front();
            chk("r_both_ack", 32'(rr_r0.ack & rr_r1.ack), 32'd0);
            chk("r_id", 32'(rr_r1.ack), 32'(re.id));
            chk("r_rdata", re.id ? rr_r1.rdata : rr_r0.rdata, re.data);
            chk("r_other_rdata", re.id ? rr_r0.rdata : rr_r1.rdata, 32'd0);
            chk("r_terr", 32'(timeout_err), 32'(re.terr));
          end
        end else begin
          chk("r_rdata_idle", rr_r0.rdata | rr_r1.rdata, 32'd0);
        end
      end
    end
  end

  // Fixed-priority monitor: grant owner at each new memory request.
  initial begin
    logic fprev;
    fprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!fp_rst_n) begin
        fprev = 1'b0;
      end else begin
        if (fp_m.req && !fprev) begin
          if (exp_fp.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fp_unexpected_req: got grant %b want no request",
                     fp_grant);
          end else begin
            chk("fp_grant", 32'(fp_grant), 32'(exp_fp.pop_front()));
          end
        end
        fprev = fp_m.req;
      end
    end
  end

  task automatic run(input logic q0, input logic q1, input int nacks);
    int got;
    got = 0;
    rr_r0.req = q0;
    rr_r1.req = q1;
    for (int i = 0; i < 60 && got < nacks; i++) begin
      tick();
      if (rr_r0.ack || rr_r1.ack) got++;
    end
    rr_r0.req = 1'b0;
    rr_r1.req = 1'b0;
    chk("run_ack_count", 32'(got), 32'(nacks));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0;
    fp_rst_n = 1'b0;
    rr_r0.req = 1'b0;
    rr_r0.we = 1'b0;
    rr_r0.addr = '0;
    rr_r0.wdata = '0;
    rr_r1.req = 1'b0;
    rr_r1.we = 1'b0;
    rr_r1.addr = '0;
    rr_r1.wdata = '0;
    #12;
    chk("rst_m_req", 32'(rr_m.req), 32'd0);
    chk("rst_m_we", 32'(rr_m.we), 32'd0);
    chk("rst_m_addr", rr_m.addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_acks", 32'({rr_r1.ack, rr_r0.ack}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single read from r1
    rr_r1.we = 1'b0;
    rr_r1.addr = 32'h0000_0040;
    rr_r1.wdata = '0;
    mem_lat = 2;
    mem_data = 32'h1234_5678;
    exp_m.push_back('{1'b1, 1'b0, 32'h40, 32'h0, 3});
    exp_r.push_back('{1'b1, 32'h1234_5678, 1'b0});
    run(1'b0, 1'b1, 1);
    tick();

    // single write from r0
    rr_r0.we = 1'b1;
    rr_r0.addr = 32'h0000_0100;
    rr_r0.wdata = 32'hCAFE_F00D;
    mem_lat = 1;
    mem_data = 32'h0;
    exp_m.push_back('{1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 2});
    exp_r.push_back('{1'b0, 32'h0, 1'b0});
    run(1'b1, 1'b0, 1);
    tick();

    // m_ack on the final watchdog cycle wins
    rr_r1.we = 1'b0;
    rr_r1.addr = 32'h0000_0080;
    mem_lat = 3;
    mem_data = 32'h5555_AAAA;
    exp_m.push_back('{1'b1, 1'b0, 32'h80, 32'h0, 4});
    exp_r.push_back('{1'b1, 32'h5555_AAAA, 1'b0});
    run(1'b0, 1'b1, 1);
    tick();
    chk("edge_terr", 32'(timeout_err), 32'd0);

    // watchdog expiry
    rr_r0.we = 1'b0;
    rr_r0.addr = 32'h0000_00C0;
    rr_r0.wdata = '0;
    mem_lat = -1;
    exp_m.push_back('{1'b0, 1'b0, 32'hC0, 32'h0, 4});
    exp_r.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
    run(1'b1, 1'b0, 1);
    stray = 1'b1;
    tick();
    tick();
    tick();
    chk("to_terr_sticky", 32'(timeout_err), 32'd1);
    chk("to_m_req_low", 32'(rr_m.req), 32'd0);
    chk("to_busy_low", 32'(busy), 32'd0);

    // contention: round-robin and fixed priority side by side
    rst_n = 1'b0;
    tick();
    chk("rst2_terr", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    fp_rst_n = 1'b1;
    tick();
    rr_r0.addr = 32'h0000_0200;
    rr_r1.addr = 32'h0000_0300;
    rr_r1.we = 1'b0;
    mem_lat = 0;
    mem_data = 32'h0000_C0DE;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2) == 1;
      exp_m.push_back('{g, 1'b0, g ? 32'h300 : 32'h200, 32'h0, 1});
      exp_r.push_back('{g, 32'h0000_C0DE, 1'b0});
      exp_fp.push_back(1'b1);
    end
    run(1'b1, 1'b1, 4);
    tick();
    fp_rst_n = 1'b0;
    tick();

    // reset in the middle of a transaction
    rr_r1.addr = 32'h0000_0400;
    mem_lat = -1;
    exp_m.push_back('{1'b1, 1'b0, 32'h400, 32'h0, 0});
    rr_r1.req = 1'b1;
    tick();
    tick();
    chk("pre_rst_m_req", 32'(rr_m.req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_req", 32'(rr_m.req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_acks", 32'({rr_r1.ack, rr_r0.ack}), 32'd0);
    rr_r1.req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rr_r0.addr = 32'h0000_0500;
    rr_r1.addr = 32'h0000_0600;
    mem_lat = 1;
    mem_data = 32'h7777_0001;
    exp_m.push_back('{1'b0, 1'b0, 32'h500, 32'h0, 2});
    exp_r.push_back('{1'b0, 32'h7777_0001, 1'b0});
    run(1'b1, 1'b1, 1);
    tick();
    tick();
    tick();

    chk("left_exp_m", 32'(exp_m.size()), 32'd0);
    chk("left_exp_r", 32'(exp_r.size()), 32'd0);
    chk("left_exp_fp", 32'(exp_fp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
